// File: rtl/seq_detect_sched_if.sv
// Request/result bus for the shared sequence detector: per-channel serial handshake
// plus the registered per-bit detection report.
interface seq_detect_sched_if #(
    parameter int unsigned NCH = 4
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]  req_valid;
    logic [NCH-1:0]  req_bit;
    logic [NCH-1:0]  req_ready;
    logic            det_valid;
    logic [CH_W-1:0] det_ch;
    logic            det_hit;

    modport master (
        output req_valid,
        output req_bit,
        input  req_ready,
        input  det_valid,
        input  det_ch,
        input  det_hit
    );

    modport slave (
        input  req_valid,
        input  req_bit,
        output req_ready,
        output det_valid,
        output det_ch,
        output det_hit
    );
endinterface

// File: rtl/seq_detect_sched.sv
// Round-robin time-multiplexed 3-bit sequence detector shared by NCH serial channels,
// with per-channel saved context and saturating hit counters.
module seq_detect_sched #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned CNT_W   = 8,
    parameter logic [2:0]  PATTERN = 3'b110
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic [NCH-1:0]       flush,
    output logic [NCH*CNT_W-1:0] hit_cnt,
    seq_detect_sched_if.slave    bus
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [1:0]       hist_q [NCH];
    logic [1:0]       fill_q [NCH];
    logic [CNT_W-1:0] cnt_q  [NCH];

    logic             det_valid_q;
    logic [CH_W-1:0]  det_ch_q;
    logic             det_hit_q;

    logic [NCH-1:0]   elig;
    logic [NCH-1:0]   gnt;
    logic             gnt_any;
    logic [CH_W-1:0]  gnt_ch;
    logic [CH_W-1:0]  idx;
    logic             gnt_bit;
    logic [1:0]       cur_hist;
    logic [1:0]       cur_fill;
    logic             hit;

    // Flush and reset both mask a channel out of arbitration for the cycle.
    assign elig = bus.req_valid & ~flush & {NCH{en & ~clr}};

    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = CH_W'((32'(ptr_q) + k) % NCH);
            if (!gnt_any && elig[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_ch   = idx;
            end
        end
    end

    always_comb begin
        gnt_bit  = bus.req_bit[gnt_ch];
        cur_hist = hist_q[gnt_ch];
        cur_fill = fill_q[gnt_ch];
        hit      = gnt_any && (cur_fill == 2'd2) && ({cur_hist, gnt_bit} == PATTERN);
        ptr_d    = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_ch == CH_W'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_hit_q   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            det_valid_q <= gnt_any;
            if (gnt_any) begin
                det_ch_q  <= gnt_ch;
                det_hit_q <= hit;
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                // Flush wins over any increment still owed to a pending report.
                if (flush[i]) begin
                    hist_q[i] <= '0;
                    fill_q[i] <= '0;
                    cnt_q[i]  <= '0;
                end else if (gnt[i]) begin
                    hist_q[i] <= {hist_q[i][0], gnt_bit};
                    if (fill_q[i] != 2'd2) begin
                        fill_q[i] <= fill_q[i] + 2'd1;
                    end
                    if (hit && (cnt_q[i] != '1)) begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.req_ready = gnt;
    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;
    assign bus.det_hit   = det_hit_q;

    for (genvar i = 0; i < NCH; i++) begin : g_cnt_out
        assign hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: a reference model predicts grants and
// detection reports; a monitor pops expected reports as det_valid appears.
module tb_seq_detect_sched;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [2:0]  PAT   = 3'b110;

    logic                 clk;
    logic                 clr;
    logic                 en;
    logic [NCH-1:0]       flush;
    logic [NCH*CNT_W-1:0] hit_cnt;

    seq_detect_sched_if #(.NCH(NCH)) bus ();

    seq_detect_sched #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .PATTERN (PAT)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .flush   (flush),
        .hit_cnt (hit_cnt),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int   ch;
        logic hit;
    } exp_t;
    exp_t sb[$];

    int         m_ptr;
    logic [1:0] m_hist [NCH];
    int         m_fill [NCH];
    int         m_cnt  [NCH];
    logic [NCH-1:0] obs_ready;

    // Scoreboard check: each accept predicted before an edge must be reported right after it.
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            total++;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                if (bus.det_valid !== 1'b1 || bus.det_ch !== e.ch[1:0] || bus.det_hit !== e.hit) begin
                    bad++;
                    $display("FAIL det_report: got v=%0b ch=%0d hit=%0b, want v=1 ch=%0d hit=%0b",
                             bus.det_valid, bus.det_ch, bus.det_hit, e.ch, e.hit);
                end
            end else if (bus.det_valid !== 1'b0) begin
                bad++;
                $display("FAIL det_idle: got det_valid=%0b, want 0", bus.det_valid);
            end
        end
    end

    // Apply one cycle of stimulus, advance the reference model, and return at posedge+1.
    task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                         input logic [NCH-1:0] f, input logic e, input logic c);
        int   g;
        int   idx;
        logic h;
        bus.req_valid = v;
        bus.req_bit   = b;
        flush         = f;
        en            = e;
        clr           = c;
        #4;
        g = -1;
        if (!c && e) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (m_ptr + k) % NCH;
                if (g < 0 && v[idx] && !f[idx]) g = idx;
            end
        end
        obs_ready = bus.req_ready;
        if (c) begin
            m_ptr = 0;
            for (int i = 0; i < NCH; i++) begin
                m_hist[i] = 2'b00; m_fill[i] = 0; m_cnt[i] = 0;
            end
            sb.delete();
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (f[i]) begin
                    m_hist[i] = 2'b00; m_fill[i] = 0; m_cnt[i] = 0;
                end
            end
            if (g >= 0) begin
                h = (m_fill[g] == 2) && ({m_hist[g], b[g]} == PAT);
                sb.push_back('{g, h});
                m_hist[g] = {m_hist[g][0], b[g]};
                if (m_fill[g] < 2) m_fill[g]++;
                if (h && m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g]++;
                m_ptr = (g + 1) % NCH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
            total++;
            if (obs_ready !== 4'h0) begin
                bad++;
                $display("FAIL reset_ready: got %b, want 0000", obs_ready);
            end
            total++;
            if (bus.det_valid !== 1'b0 || bus.det_ch !== 2'd0 || bus.det_hit !== 1'b0 ||
                hit_cnt !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got v=%0b ch=%0d hit=%0b cnt=%h, want all zero",
                         bus.det_valid, bus.det_ch, bus.det_hit, hit_cnt);
            end
        end
        mon_on = 1'b1;
    endtask

    task automatic test_single();
        logic [5:0] s;
        s = 6'b110110;
        for (int k = 0; k < 6; k++) begin
            drive(4'b0100, {1'b0, s[5-k], 2'b00}, 4'h0, 1'b1, 1'b0);
            total++;
            if (obs_ready !== 4'b0100) begin
                bad++;
                $display("FAIL single_ready[%0d]: got %b, want 0100", k, obs_ready);
            end
            total++;
            if (bus.det_ch !== 2'd2 || bus.det_hit !== (k == 2 || k == 5)) begin
                bad++;
                $display("FAIL single_hit[%0d]: got ch=%0d hit=%0b, want ch=2 hit=%0b",
                         k, bus.det_ch, bus.det_hit, (k == 2 || k == 5));
            end
        end
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        total++;
        if (hit_cnt !== {8'd0, 8'd2, 8'd0, 8'd0}) begin
            bad++;
            $display("FAIL single_cnt: got %h, want 00020000", hit_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] want;
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            want = 4'b0001 << (k % 4);
            drive(4'hF, 4'($urandom), 4'h0, 1'b1, 1'b0);
            total++;
            if (obs_ready !== want) begin
                bad++;
                $display("FAIL rr_grant[%0d]: got %b, want %b", k, obs_ready, want);
            end
        end
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < NCH; i++) begin
            total++;
            if (hit_cnt[i*CNT_W +: CNT_W] !== CNT_W'(m_cnt[i])) begin
                bad++;
                $display("FAIL rr_cnt[%0d]: got %0d, want %0d", i, hit_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
            end
        end
    endtask

    task automatic test_interleave();
        logic [2:0]     s;
        logic           bt;
        logic [NCH-1:0] want;
        s = 3'b110;
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            bt   = s[2 - k/2];
            want = (k % 2 == 1) ? 4'b1000 : 4'b0001;
            drive(4'b1001, {bt, 2'b00, bt}, 4'h0, 1'b1, 1'b0);
            total++;
            if (obs_ready !== want) begin
                bad++;
                $display("FAIL inter_grant[%0d]: got %b, want %b", k, obs_ready, want);
            end
        end
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        total++;
        if (hit_cnt !== {8'd1, 8'd0, 8'd0, 8'd1}) begin
            bad++;
            $display("FAIL inter_cnt: got %h, want 01000001", hit_cnt);
        end
    endtask

    task automatic test_flush();
        logic [2:0] s;
        s = 3'b110;
        for (int k = 0; k < 3; k++) drive(4'b0010, {2'b00, s[2-k], 1'b0}, 4'h0, 1'b1, 1'b0);
        total++;
        if (bus.det_hit !== 1'b1 || bus.det_ch !== 2'd1 || hit_cnt[1*CNT_W +: CNT_W] !== 8'd1) begin
            bad++;
            $display("FAIL flush_prehit: got hit=%0b ch=%0d cnt=%0d, want 1 1 1",
                     bus.det_hit, bus.det_ch, hit_cnt[1*CNT_W +: CNT_W]);
        end
        // ch1 flushed while requesting; ch0 takes the slot instead.
        drive(4'b0011, 4'b0010, 4'b0010, 1'b1, 1'b0);
        total++;
        if (obs_ready !== 4'b0001) begin
            bad++;
            $display("FAIL flush_ready: got %b, want 0001", obs_ready);
        end
        total++;
        if (hit_cnt[1*CNT_W +: CNT_W] !== 8'd0) begin
            bad++;
            $display("FAIL flush_cnt: got %0d, want 0", hit_cnt[1*CNT_W +: CNT_W]);
        end
        drive(4'b0010, 4'b0010, 4'h0, 1'b1, 1'b0);
        drive(4'b0010, 4'b0000, 4'h0, 1'b1, 1'b0);
        total++;
        if (bus.det_hit !== 1'b0 || obs_ready !== 4'b0010) begin
            bad++;
            $display("FAIL flush_nohit: got hit=%0b ready=%b, want hit=0 ready=0010",
                     bus.det_hit, obs_ready);
        end
        for (int k = 0; k < 3; k++) drive(4'b0010, {2'b00, s[2-k], 1'b0}, 4'h0, 1'b1, 1'b0);
        total++;
        if (bus.det_hit !== 1'b1 || hit_cnt[1*CNT_W +: CNT_W] !== 8'd1) begin
            bad++;
            $display("FAIL flush_rehit: got hit=%0b cnt=%0d, want 1 1",
                     bus.det_hit, hit_cnt[1*CNT_W +: CNT_W]);
        end
    endtask

    task automatic test_saturation();
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        for (int k = 0; k < 905; k++) begin
            drive(4'b0001, {3'b000, logic'(k % 3 != 2)}, 4'h0, 1'b1, 1'b0);
        end
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        total++;
        if (hit_cnt[0 +: CNT_W] !== 8'hFF) begin
            bad++;
            $display("FAIL sat_cnt: got %0d, want 255", hit_cnt[0 +: CNT_W]);
        end
    endtask

    task automatic test_clr_midstream();
        drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
        total++;
        if (obs_ready !== 4'h0 || bus.det_valid !== 1'b0 || hit_cnt !== '0) begin
            bad++;
            $display("FAIL clr_mid: got ready=%b v=%0b cnt=%h, want 0000 0 0",
                     obs_ready, bus.det_valid, hit_cnt);
        end
        drive(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        total++;
        if (obs_ready !== 4'b0001) begin
            bad++;
            $display("FAIL clr_ptr: got %b, want 0001", obs_ready);
        end
        drive(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        total++;
        if (obs_ready !== 4'h0) begin
            bad++;
            $display("FAIL en_off: got %b, want 0000", obs_ready);
        end
        drive(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        total++;
        if (obs_ready !== 4'b0010) begin
            bad++;
            $display("FAIL en_ptr_hold: got %b, want 0010", obs_ready);
        end
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    endtask

    initial begin
        clr           = 1'b1;
        en            = 1'b0;
        flush         = '0;
        bus.req_valid = '0;
        bus.req_bit   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_interleave();
        test_flush();
        test_saturation();
        test_clr_midstream();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d outstanding, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
